// File: rtl/loader_pkg.sv
`default_nettype none
// loader_pkg: shared state encoding and constants for the boot-time instruction loader.
package loader_pkg;
   localparam int BYTE_W    = 8;
   localparam int MAX_WORDS = 1024;

   typedef enum logic [2:0] {
      IDLE,
      LEN_HI,
      LEN_LO,
      DATA_HI,
      DATA_LO,
      CHK,
      DONE,
      ERR
   } state_e;
endpackage
`default_nettype wire

// File: rtl/word_assembler.sv
`default_nettype none
// word_assembler: pairs stream bytes into instruction words, issues the registered
// memory write one cycle after the low byte, and keeps the running XOR checksum.
module word_assembler
   import loader_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              hi_en,
   input  logic              lo_en,
   input  logic [BYTE_W-1:0] byte_in,
   input  logic [ADDR_W-1:0] addr_in,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic [BYTE_W-1:0] checksum
);

   logic [BYTE_W-1:0] hi_q, hi_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;
   logic [BYTE_W-1:0] chk_q, chk_d;

   always_comb begin
      hi_d      = hi_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      chk_d     = chk_q;
      if (clear) begin
         chk_d = '0;
      end
      if (hi_en) begin
         hi_d  = byte_in;
         chk_d = chk_q ^ byte_in;
      end
      // The strobe, address and data all land together on the edge after the low byte.
      if (lo_en) begin
         wr_en_d   = 1'b1;
         wr_addr_d = addr_in;
         wr_data_d = DATA_W'({hi_q, byte_in});
         chk_d     = chk_q ^ byte_in;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         hi_q      <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         chk_q     <= '0;
      end else begin
         hi_q      <= hi_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         chk_q     <= chk_d;
      end
   end

   assign wr_en    = wr_en_q;
   assign wr_addr  = wr_addr_q;
   assign wr_data  = wr_data_q;
   assign checksum = chk_q;

endmodule
`default_nettype wire

// File: rtl/inst_loader.sv
`default_nettype none
// inst_loader: streams a length-prefixed, checksummed program into instruction memory
// and holds the core in reset until a load completes with a matching checksum.
module inst_loader
   import loader_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [BYTE_W-1:0] byteIn,
   input  logic              byteValid,
   output logic              byteReady,
   output logic              imWrEn,
   output logic [ADDR_W-1:0] imWrAddr,
   output logic [DATA_W-1:0] imWrData,
   output logic              coreHold,
   output logic              done,
   output logic              error
);

   state_e            state_q, state_d;
   logic [15:0]       len_q, len_d, len_w;
   logic [ADDR_W:0]   cnt_q, cnt_d, cnt_inc;
   logic              hold_q, hold_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              ready_q, ready_d;
   logic              accept, clear, hi_en, lo_en;
   logic [BYTE_W-1:0] checksum;

   assign accept  = byteValid & ready_q;
   assign cnt_inc = cnt_q + 1'b1;

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      len_w   = {len_q[15:8], byteIn};
      cnt_d   = cnt_q;
      hold_d  = hold_q;
      done_d  = done_q;
      err_d   = err_q;
      clear   = 1'b0;
      hi_en   = 1'b0;
      lo_en   = 1'b0;
      case (state_q)
         IDLE, DONE, ERR: begin
            if (start) begin
               state_d = LEN_HI;
               cnt_d   = '0;
               clear   = 1'b1;
               hold_d  = 1'b1;
               done_d  = 1'b0;
               err_d   = 1'b0;
            end
         end
         LEN_HI: begin
            if (accept) begin
               len_d[15:8] = byteIn;
               state_d     = LEN_LO;
            end
         end
         LEN_LO: begin
            if (accept) begin
               len_d = len_w;
               if (len_w > 16'(MAX_WORDS)) begin
                  state_d = ERR;
                  err_d   = 1'b1;
               end else if (len_w == 16'd0) begin
                  state_d = CHK;
               end else begin
                  state_d = DATA_HI;
               end
            end
         end
         DATA_HI: begin
            if (accept) begin
               hi_en   = 1'b1;
               state_d = DATA_LO;
            end
         end
         DATA_LO: begin
            if (accept) begin
               lo_en   = 1'b1;
               cnt_d   = cnt_inc;
               state_d = (16'(cnt_inc) == len_q) ? CHK : DATA_HI;
            end
         end
         CHK: begin
            if (accept) begin
               if (byteIn == checksum) begin
                  state_d = DONE;
                  done_d  = 1'b1;
                  hold_d  = 1'b0;
               end else begin
                  state_d = ERR;
                  err_d   = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      // Ready follows the state being entered so it is valid from the first cycle there.
      ready_d = (state_d inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHK});
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         len_q   <= '0;
         cnt_q   <= '0;
         hold_q  <= 1'b1;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         hold_q  <= hold_d;
         done_q  <= done_d;
         err_q   <= err_d;
         ready_q <= ready_d;
      end
   end

   word_assembler #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_word_assembler (
      .clk      (clk),
      .rst      (rst),
      .clear    (clear),
      .hi_en    (hi_en),
      .lo_en    (lo_en),
      .byte_in  (byteIn),
      .addr_in  (cnt_q[ADDR_W-1:0]),
      .wr_en    (imWrEn),
      .wr_addr  (imWrAddr),
      .wr_data  (imWrData),
      .checksum (checksum)
   );

   assign byteReady = ready_q;
   assign coreHold  = hold_q;
   assign done      = done_q;
   assign error     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_inst_loader.sv
`default_nettype none
// tb_inst_loader: table vectors, hand-written reset/restart sequences and randomized
// loads checked against a stream-level reference model.
module tb_inst_loader;

   logic        clk;
   logic        rst;
   logic        start;
   logic [7:0]  byteIn;
   logic        byteValid;
   logic        byteReady;
   logic        imWrEn;
   logic [9:0]  imWrAddr;
   logic [15:0] imWrData;
   logic        coreHold;
   logic        done;
   logic        error;

   inst_loader #(.ADDR_W(10), .DATA_W(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .byteIn    (byteIn),
      .byteValid (byteValid),
      .byteReady (byteReady),
      .imWrEn    (imWrEn),
      .imWrAddr  (imWrAddr),
      .imWrData  (imWrData),
      .coreHold  (coreHold),
      .done      (done),
      .error     (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          tests = 0;
   int          fails = 0;
   logic [25:0] wr_q[$];
   logic [25:0] exp_wr[$];
   logic [7:0]  stim[$];
   bit          exp_done;
   bit          exp_err;

   typedef struct {
      int          n;
      logic [7:0]  s [8];
      bit          done;
      bit          err;
      int          nwr;
      logic [15:0] w [2];
   } vec_t;

   vec_t vecs [6];

   always @(negedge clk) begin
      if (imWrEn === 1'b1) wr_q.push_back({imWrAddr, imWrData});
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input bit gaps);
      int n;
      if (gaps) begin
         int k;
         k = $urandom_range(0, 3);
         for (int g = 0; g < k; g++) begin
            byteValid = 1'b0;
            byteIn    = 8'($urandom);
            start     = 1'($urandom_range(0, 1));
            @(negedge clk);
            start = 1'b0;
         end
      end
      byteIn    = b;
      byteValid = 1'b1;
      n = 0;
      while (byteReady !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("byte_ready", 32'(byteReady), 32'd1);
      @(negedge clk);
      byteValid = 1'b0;
   endtask

   task automatic do_load(input bit gaps);
      wr_q.delete();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("start_state", 32'({coreHold, done, error, byteReady}), 32'b1001);
      foreach (stim[i]) send_byte(stim[i], gaps);
      repeat (2) @(negedge clk);
      chk("final_flags", 32'({done, error, coreHold, byteReady}),
          32'({exp_done, exp_err, ~exp_done, 1'b0}));
      chk("wr_count", 32'(wr_q.size()), 32'(exp_wr.size()));
      for (int i = 0; i < wr_q.size() && i < exp_wr.size(); i++)
         chk("wr_word", 32'(wr_q[i]), 32'(exp_wr[i]));
   endtask

   // Reference: interpret the byte stream directly as length, word pairs and XOR checksum.
   task automatic build_model();
      int         len;
      logic [7:0] x;
      exp_wr.delete();
      len = int'({stim[0], stim[1]});
      if (len > 1024) begin
         exp_done = 1'b0;
         exp_err  = 1'b1;
      end else begin
         x = 8'h00;
         for (int i = 0; i < len; i++) begin
            exp_wr.push_back({10'(i), stim[2+2*i], stim[3+2*i]});
            x = x ^ stim[2+2*i] ^ stim[3+2*i];
         end
         exp_done = (stim[2+2*len] == x);
         exp_err  = ~exp_done;
      end
   endtask

   task automatic make_random(input int len, input bit bad);
      logic [15:0] l16;
      logic [7:0]  x;
      logic [7:0]  b;
      l16 = 16'(len);
      x   = 8'h00;
      stim.delete();
      stim.push_back(l16[15:8]);
      stim.push_back(l16[7:0]);
      for (int i = 0; i < 2 * len; i++) begin
         b = 8'($urandom);
         x = x ^ b;
         stim.push_back(b);
      end
      if (bad) x = x ^ 8'($urandom_range(1, 255));
      stim.push_back(x);
   endtask

   initial begin
      rst       = 1'b0;
      start     = 1'b0;
      byteIn    = 8'h00;
      byteValid = 1'b0;

      // 12^34^AB^CD = 0x40 is the matching checksum for the two-word stream.
      vecs[0] = '{7, '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40, 8'h00}, 1'b1, 1'b0, 2, '{16'h1234, 16'hABCD}};
      vecs[1] = '{7, '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hB8, 8'h00}, 1'b0, 1'b1, 2, '{16'h1234, 16'hABCD}};
      vecs[2] = '{2, '{8'h04, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b0, 1'b1, 0, '{16'h0000, 16'h0000}};
      vecs[3] = '{3, '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b1, 1'b0, 0, '{16'h0000, 16'h0000}};
      vecs[4] = '{3, '{8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b0, 1'b1, 0, '{16'h0000, 16'h0000}};
      vecs[5] = '{5, '{8'h00, 8'h01, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00}, 1'b1, 1'b0, 1, '{16'hFF00, 16'h0000}};

      repeat (3) @(negedge clk);
      chk("reset_flags", 32'({byteReady, imWrEn, coreHold, done, error}), 32'b00100);
      chk("reset_wr", 32'({imWrAddr, imWrData}), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      chk("idle_flags", 32'({byteReady, imWrEn, coreHold, done, error}), 32'b00100);

      for (int v = 0; v < 6; v++) begin
         stim.delete();
         for (int j = 0; j < vecs[v].n; j++) stim.push_back(vecs[v].s[j]);
         exp_done = vecs[v].done;
         exp_err  = vecs[v].err;
         exp_wr.delete();
         for (int j = 0; j < vecs[v].nwr; j++) exp_wr.push_back({10'(j), vecs[v].w[j]});
         do_load(1'b0);
      end

      // Reset mid-load right after the first word is written; start asserted alongside.
      stim.delete();
      wr_q.delete();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      send_byte(8'h00, 1'b0);
      send_byte(8'h03, 1'b0);
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      chk("first_write", 32'({imWrEn, imWrAddr, imWrData}), 32'({1'b1, 10'd0, 16'h1122}));
      rst       = 1'b0;
      start     = 1'b1;
      byteValid = 1'b1;
      byteIn    = 8'h33;
      @(negedge clk);
      chk("midload_rst_flags", 32'({coreHold, done, error, byteReady, imWrEn}), 32'b10000);
      chk("midload_rst_wr", 32'({imWrAddr, imWrData}), 32'd0);
      rst   = 1'b1;
      start = 1'b0;
      repeat (5) @(negedge clk);
      chk("no_wr_after_rst", 32'(wr_q.size()), 32'd1);
      chk("idle_after_rst", 32'({byteReady, coreHold}), 32'b01);
      byteValid = 1'b0;
      stim = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
      build_model();
      do_load(1'b0);

      // Same 4-word stream with and without gaps and stray start pulses.
      make_random(4, 1'b0);
      build_model();
      do_load(1'b0);
      do_load(1'b1);

      for (int r = 0; r < 8; r++) begin
         make_random($urandom_range(1, 6), ($urandom_range(0, 3) == 0));
         build_model();
         do_load(1'b1);
      end

      make_random(1024, 1'b0);
      build_model();
      do_load(1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
